// File: rtl/wb_regfile.sv
// wb_regfile: writeback-stage result mux, 31-entry register file and
// retired-instruction counter.
// Optional build macro WB_BYPASS_EN: forwards the WB result straight to the
// decode read ports when the same register is written and read in one cycle.
module wb_regfile #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            RegWriteW,
    input  logic [1:0]      ResultSrcW,
    input  logic            ValidW,
    input  logic [XLEN-1:0] ALUResultW,
    input  logic [XLEN-1:0] ReadDataW,
    input  logic [XLEN-1:0] PCPlus4W,
    input  logic [4:0]      RdW,
    input  logic [4:0]      Rs1D,
    input  logic [4:0]      Rs2D,
    output logic [XLEN-1:0] RD1D,
    output logic [XLEN-1:0] RD2D,
    output logic [XLEN-1:0] ResultW,
    output logic [63:0]     InstretW
);

    // x0 is hardwired to zero, so only x1..x31 have storage
    logic [XLEN-1:0] rf_q [1:31];
    logic [XLEN-1:0] rf_d [1:31];
    logic [63:0]     instret_q;
    logic [63:0]     instret_d;
    logic            wr_en;

    // Writeback result select; the reserved encoding yields zero
    always_comb begin
        case (ResultSrcW)
            2'b00:   ResultW = ALUResultW;
            2'b01:   ResultW = ReadDataW;
            2'b10:   ResultW = PCPlus4W;
            default: ResultW = '0;
        endcase
    end

    // Bubbles and writes to x0 never touch the array
    assign wr_en = RegWriteW & ValidW & (RdW != 5'd0);

    // Next-state: one register update and the retire count (wraps naturally)
    always_comb begin
        rf_d = rf_q;
        if (wr_en) rf_d[RdW] = ResultW;
        instret_d = instret_q + {63'd0, ValidW};
    end

    // State update; reset clears everything without waiting for a clock
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < 32; i++) rf_q[i] <= '0;
            instret_q <= '0;
        end else begin
            rf_q      <= rf_d;
            instret_q <= instret_d;
        end
    end

    // Decode read port 1: stored value, optionally bypassed from WB
    always_comb begin
        RD1D = '0;
        if (Rs1D != 5'd0) RD1D = rf_q[Rs1D];
`ifdef WB_BYPASS_EN
        if (wr_en && (RdW == Rs1D)) RD1D = ResultW;
`endif
    end

    // Decode read port 2: stored value, optionally bypassed from WB
    always_comb begin
        RD2D = '0;
        if (Rs2D != 5'd0) RD2D = rf_q[Rs2D];
`ifdef WB_BYPASS_EN
        if (wr_en && (RdW == Rs2D)) RD2D = ResultW;
`endif
    end

    assign InstretW = instret_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: behavioural register-file model,
// per-cycle compare at the falling edge, directed literal checks and
// randomized writeback traffic with occasional asynchronous resets.
module tb_wb_regfile;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            RegWriteW;
    logic [1:0]      ResultSrcW;
    logic            ValidW;
    logic [XLEN-1:0] ALUResultW, ReadDataW, PCPlus4W;
    logic [4:0]      RdW, Rs1D, Rs2D;
    logic [XLEN-1:0] RD1D, RD2D, ResultW;
    logic [63:0]     InstretW;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    // behavioural model state
    logic [XLEN-1:0] m_rf [32];
    logic [63:0]     m_instret;

    wb_regfile #(.XLEN(XLEN)) dut (
        .clk(clk), .reset(reset), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
        .ValidW(ValidW), .ALUResultW(ALUResultW), .ReadDataW(ReadDataW),
        .PCPlus4W(PCPlus4W), .RdW(RdW), .Rs1D(Rs1D), .Rs2D(Rs2D),
        .RD1D(RD1D), .RD2D(RD2D), .ResultW(ResultW), .InstretW(InstretW)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [XLEN-1:0] m_result();
        case (ResultSrcW)
            2'd0:    return ALUResultW;
            2'd1:    return ReadDataW;
            2'd2:    return PCPlus4W;
            default: return '0;
        endcase
    endfunction

    function automatic bit m_writes();
        return RegWriteW && ValidW && RdW != 0;
    endfunction

    function automatic logic [XLEN-1:0] m_read(input logic [4:0] idx);
        if (reset || idx == 0) return '0;
`ifdef WB_BYPASS_EN
        if (m_writes() && RdW == idx) return m_result();
`endif
        return m_rf[idx];
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
        m_instret = '0;
    endtask

    // model clock edge: inputs are stable here (driven 1 time unit after edges)
    always @(posedge clk) begin
        if (!reset) begin
            if (m_writes()) m_rf[RdW] = m_result();
            if (ValidW) m_instret = m_instret + 64'd1;
        end
    end

    // compare all outputs against the model mid-cycle
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ResultW", {32'd0, ResultW}, {32'd0, m_result()});
            chk("RD1D", {32'd0, RD1D}, {32'd0, m_read(Rs1D)});
            chk("RD2D", {32'd0, RD2D}, {32'd0, m_read(Rs2D)});
            chk("InstretW", InstretW, m_instret);
        end
    end

    task automatic idle();
        RegWriteW = 0; ValidW = 0; ResultSrcW = 0;
        ALUResultW = 0; ReadDataW = 0; PCPlus4W = 0; RdW = 0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] rd, input logic [1:0] src, input logic [XLEN-1:0] v);
        RegWriteW = 1; ValidW = 1; RdW = rd; ResultSrcW = src;
        ALUResultW = v; ReadDataW = v; PCPlus4W = v;
    endtask

    initial begin
        reset = 1;
        idle();
        Rs1D = 0; Rs2D = 0;
        m_clear();
        #2;
        // reset: every index reads zero, result mux still live
        for (int i = 0; i < 32; i++) begin
            Rs1D = 5'(i); Rs2D = 5'(31 - i);
            #1;
            chk("rst_rd1", {32'd0, RD1D}, 64'd0);
            chk("rst_rd2", {32'd0, RD2D}, 64'd0);
        end
        chk("rst_instret", InstretW, 64'd0);
        ResultSrcW = 2'd0; ALUResultW = 32'h0000_00AA;
        #1 chk("rst_result_live", {32'd0, ResultW}, 64'h0000_00AA);
        idle();
        // release reset between edges
        @(negedge clk); #2 reset = 0;
        chk_en = 1;

        // load x5 from memory data
        next(); wr(5'd5, 2'd1, 32'hDEAD_BEEF);
        next(); idle(); Rs1D = 5; #1;
        chk("x5_load", {32'd0, RD1D}, 64'hDEAD_BEEF);
        chk("instret_1", InstretW, 64'd1);

        // x0 write is dropped; bubble write to x7 dropped
        wr(5'd0, 2'd0, 32'h1234_5678);
        next(); idle(); Rs2D = 0;
        RegWriteW = 1; ValidW = 0; RdW = 7; ALUResultW = 32'h7777_7777;
        #1 chk("x0_zero", {32'd0, RD2D}, 64'd0);
        next(); idle(); Rs1D = 7; #1;
        chk("x7_unchanged", {32'd0, RD1D}, 64'd0);
        chk("instret_2", InstretW, 64'd2);

        // same-cycle write and read of x9
        wr(5'd9, 2'd0, 32'h0000_0055);
        next(); wr(5'd9, 2'd2, 32'h0000_0104); Rs1D = 9; #1;
`ifdef WB_BYPASS_EN
        chk("x9_bypass", {32'd0, RD1D}, 64'h0000_0104);
`else
        chk("x9_old", {32'd0, RD1D}, 64'h0000_0055);
`endif
        next(); idle(); #1 chk("x9_after", {32'd0, RD1D}, 64'h0000_0104);

        // reserved select writes zero and still retires
        wr(5'd9, 2'd3, 32'hFFFF_FFFF);
        next(); idle(); #1;
        chk("x9_reserved", {32'd0, RD1D}, 64'd0);
        chk("instret_5", InstretW, 64'd5);

        // async reset between edges wipes x3 immediately
        wr(5'd3, 2'd0, 32'hA5A5_A5A5);
        next(); idle(); Rs1D = 3; #1;
        chk("x3_written", {32'd0, RD1D}, 64'hA5A5_A5A5);
        #1 reset = 1; m_clear();
        #1 chk("x3_async_clr", {32'd0, RD1D}, 64'd0);
        chk("instret_async_clr", InstretW, 64'd0);
        // edge during reset: no write, no count
        wr(5'd3, 2'd0, 32'h1111_1111);
        next(); idle(); #1;
        chk("rst_no_write", {32'd0, RD1D}, 64'd0);
        chk("rst_no_count", InstretW, 64'd0);
        reset = 0;

        // counter wrap via preload
        ValidW = 0;
        force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFE;
        #1 release dut.instret_q;
        m_instret = 64'hFFFF_FFFF_FFFF_FFFE;
        ValidW = 1;
        next(); #1 chk("instret_max", InstretW, 64'hFFFF_FFFF_FFFF_FFFF);
        next(); ValidW = 0; #1 chk("instret_wrap", InstretW, 64'd0);

        // randomized traffic, model-checked every falling edge
        for (int n = 0; n < 600; n++) begin
            next();
            RegWriteW  = ($urandom_range(0, 3) != 0);
            ValidW     = ($urandom_range(0, 4) != 0);
            ResultSrcW = 2'($urandom_range(0, 3));
            ALUResultW = $urandom;
            ReadDataW  = $urandom;
            PCPlus4W   = $urandom;
            RdW        = 5'($urandom_range(0, 31));
            Rs1D       = ($urandom_range(0, 3) == 0) ? RdW : 5'($urandom_range(0, 31));
            Rs2D       = ($urandom_range(0, 3) == 0) ? RdW : 5'($urandom_range(0, 31));
            if ($urandom_range(0, 99) == 0) begin
                #1 reset = 1; m_clear();
                #1 chk("rand_rst_rd1", {32'd0, RD1D}, 64'd0);
                reset = 0;
            end
        end

        next(); idle();
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameter: XLEN, default 32, data-path width of every result, read and register-file entry.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: RegWriteW  input  1  writeback enable from the MEM/WB control register.
REQ-005 Port: ResultSrcW  input  2  result select: 00 ALU, 01 memory, 10 PC+4, 11 reserved.
REQ-006 Port: ValidW  input  1  a real (non-bubble) instruction occupies WB this cycle.
REQ-007 Port: ALUResultW  input  XLEN  ALU result.
REQ-008 Port: ReadDataW  input  XLEN  load data.
REQ-009 Port: PCPlus4W  input  XLEN  link address.
REQ-010 Port: RdW  input  5  destination register index.
REQ-011 Port: Rs1D, Rs2D  input  5 each  decode-stage source indices.
REQ-012 Port: RD1D, RD2D  output  XLEN each  decode-stage read data, combinational.
REQ-013 Port: ResultW  output  XLEN  selected writeback result, combinational; also the forwarding source.
REQ-014 Port: InstretW  output  64  retired-instruction counter, registered.

Function
REQ-015 ResultW SHALL be ALUResultW, ReadDataW or PCPlus4W for ResultSrcW 00, 01, 10; ResultSrcW 11 SHALL give 0.
REQ-016 The register file SHALL hold 31 writable XLEN-bit entries x1..x31; x0 SHALL read 0 always.
REQ-017 Write SHALL occur on the rising clk edge when RegWriteW=1, ValidW=1 and RdW!=0; it stores ResultW into x[RdW].
REQ-018 A write with RdW=0, RegWriteW=0 or ValidW=0 SHALL leave every entry unchanged.
REQ-019 RD1D/RD2D SHALL be the asynchronous read of x[Rs1D]/x[Rs2D]; a read with index 0 SHALL return 0.
REQ-020 Write latency: a value written at edge N SHALL be visible on RD1D/RD2D from edge N onward (after clk-to-q).
REQ-021 InstretW SHALL increment by 1 at each rising edge with ValidW=1, independent of RegWriteW.
REQ-022 InstretW SHALL wrap from 2^64-1 to 0 with no flag or stall.
REQ-023 ResultSrcW=11 with RegWriteW=1 and ValidW=1 SHALL write 0 to x[RdW] (RdW!=0) and count as retired.

Reset
REQ-024 Asserting reset SHALL immediately clear x1..x31 to 0 and InstretW to 0, regardless of clk.
REQ-025 During reset no write and no increment SHALL occur; reset deasserted mid-cycle SHALL leave state unaffected until the next rising edge.
REQ-026 Outputs during reset: RD1D/RD2D = 0 for any index, ResultW still follows its inputs (combinational).

Configuration
REQ-027 Macro WB_BYPASS_EN: when defined, RD1D (RD2D) SHALL return ResultW in the same cycle whenever RegWriteW=1, ValidW=1, RdW!=0 and RdW==Rs1D (Rs2D), giving write-before-read semantics.
REQ-028 Without WB_BYPASS_EN, RD1D/RD2D SHALL return the stored value only; same-cycle WB-to-decode hazards are the hazard unit's responsibility (stall one cycle).
REQ-029 The bypass SHALL never apply to index 0; Rs1D=Rs2D=RdW SHALL bypass both ports.

Verification
REQ-030 Reset then read all 32 indices -> every RD1D/RD2D = 0, InstretW = 0.
REQ-031 RegWriteW=1, ValidW=1, ResultSrcW=01, ReadDataW=0xDEADBEEF, RdW=5; next cycle Rs1D=5 -> RD1D=0xDEADBEEF, InstretW=1.
REQ-032 Write 0x12345678 with RdW=0, then Rs2D=0 -> RD2D=0; ValidW=0 write to x7 -> x7 unchanged, InstretW unchanged.
REQ-033 Same cycle RdW=Rs1D=9, ResultSrcW=10, PCPlus4W=0x104 -> RD1D=0x104 before the edge with WB_BYPASS_EN, old x9 without it; both builds hold 0x104 after the edge.
REQ-034 Force InstretW to 2^64-1 via 2^64-1 retirements (or a bench-injected preload), ValidW=1 one more edge -> InstretW=0.
REQ-035 Assert reset asynchronously between edges after writing x3=0xA5A5A5A5 -> RD1D(Rs1D=3)=0 immediately, before the next edge.
